// File: rtl/pswitch_merger.sv
// pswitch_merger: atomic round-robin merge of agg/byp AXI streams; MERGER_STATS_EN adds per-input packet counters
module pswitch_merger #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_agg_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_agg_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_agg_tuser,
  input  logic                            s_axis_agg_tvalid,
  output logic                            s_axis_agg_tready,
  input  logic                            s_axis_agg_tlast,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_byp_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_byp_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_byp_tuser,
  input  logic                            s_axis_byp_tvalid,
  output logic                            s_axis_byp_tready,
  input  logic                            s_axis_byp_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [31:0]                     pkt_agg_cnt,
  output logic [31:0]                     pkt_byp_cnt
);
  typedef enum logic [1:0] {IDLE, SEND_AGG, SEND_BYP} state_t;
  state_t state_q, state_d;
  logic last_grant_q, last_grant_d;
  logic sel_agg, sel_byp, agg_done, byp_done;
  assign sel_agg  = state_q == SEND_AGG;
  assign sel_byp  = state_q == SEND_BYP;
  assign agg_done = sel_agg && s_axis_agg_tvalid && m_axis_tready && s_axis_agg_tlast;
  assign byp_done = sel_byp && s_axis_byp_tvalid && m_axis_tready && s_axis_byp_tlast;
  // last_grant: 1 means byp won the previous arbitration, so agg wins the next tie
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE:
        if (s_axis_agg_tvalid && (!s_axis_byp_tvalid || last_grant_q)) begin
          state_d      = SEND_AGG;
          last_grant_d = 1'b0;
        end else if (s_axis_byp_tvalid) begin
          state_d      = SEND_BYP;
          last_grant_d = 1'b1;
        end
      SEND_AGG: state_d = agg_done ? IDLE : SEND_AGG;
      SEND_BYP: state_d = byp_done ? IDLE : SEND_BYP;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end
  assign m_axis_tdata      = sel_byp ? s_axis_byp_tdata : s_axis_agg_tdata;
  assign m_axis_tkeep      = sel_byp ? s_axis_byp_tkeep : s_axis_agg_tkeep;
  assign m_axis_tuser      = sel_byp ? s_axis_byp_tuser : s_axis_agg_tuser;
  assign m_axis_tlast      = sel_byp ? s_axis_byp_tlast : s_axis_agg_tlast;
  assign m_axis_tvalid     = (sel_agg && s_axis_agg_tvalid) || (sel_byp && s_axis_byp_tvalid);
  assign s_axis_agg_tready = sel_agg && m_axis_tready;
  assign s_axis_byp_tready = sel_byp && m_axis_tready;
`ifdef MERGER_STATS_EN
  logic [31:0] agg_cnt_q, agg_cnt_d, byp_cnt_q, byp_cnt_d;
  always_comb begin
    agg_cnt_d = agg_cnt_q + 32'(agg_done);
    byp_cnt_d = byp_cnt_q + 32'(byp_done);
  end
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      agg_cnt_q <= '0;
      byp_cnt_q <= '0;
    end else begin
      agg_cnt_q <= agg_cnt_d;
      byp_cnt_q <= byp_cnt_d;
    end
  end
  assign pkt_agg_cnt = agg_cnt_q;
  assign pkt_byp_cnt = byp_cnt_q;
`else
  assign pkt_agg_cnt = '0;
  assign pkt_byp_cnt = '0;
`endif
endmodule

// File: tb/tb_pswitch_merger.sv
// tb_pswitch_merger: vector table, directed corner cases and randomized scoreboard run
module tb_pswitch_merger;
  localparam int DW = 32;
  localparam int UW = 8;
  logic clk = 0, rst = 1;
  logic [DW-1:0] adata, bdata, mdata;
  logic [DW/8-1:0] akeep, bkeep, mkeep;
  logic [UW-1:0] auser, buser, muser;
  logic av, al, ar, bv, bl, br, mv, mr, ml;
  logic [31:0] acnt, bcnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pswitch_merger #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) dut (
    .axis_aclk(clk), .axis_reset(rst),
    .s_axis_agg_tdata(adata), .s_axis_agg_tkeep(akeep), .s_axis_agg_tuser(auser),
    .s_axis_agg_tvalid(av), .s_axis_agg_tready(ar), .s_axis_agg_tlast(al),
    .s_axis_byp_tdata(bdata), .s_axis_byp_tkeep(bkeep), .s_axis_byp_tuser(buser),
    .s_axis_byp_tvalid(bv), .s_axis_byp_tready(br), .s_axis_byp_tlast(bl),
    .m_axis_tdata(mdata), .m_axis_tkeep(mkeep), .m_axis_tuser(muser),
    .m_axis_tvalid(mv), .m_axis_tready(mr), .m_axis_tlast(ml),
    .pkt_agg_cnt(acnt), .pkt_byp_cnt(bcnt));
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  // Counters exist only in the stats build; otherwise they must read zero
  function automatic logic [31:0] ecnt(logic [31:0] n);
`ifdef MERGER_STATS_EN
    return n;
`else
    return 32'(n & 0);
`endif
  endfunction
  typedef struct {bit av, al, bv, bl, mr, mv, ar, br, ml, src;} vec_t;
  vec_t tab[$];
  function automatic void add(bit a_v, a_l, b_v, b_l, m_r, e_mv, e_ar, e_br, e_ml, e_src);
    tab.push_back('{a_v, a_l, b_v, b_l, m_r, e_mv, e_ar, e_br, e_ml, e_src});
  endfunction
  typedef struct packed {logic [DW-1:0] d; logic [DW/8-1:0] k; logic [UW-1:0] u; logic l;} beat_t;
  beat_t exp_a[$], exp_b[$];
  bit mon_en = 0, in_pkt = 0, cur = 0, gap_chk = 0, done_a = 0, done_b = 0;
  int mcnt[2];
  beat_t eb;
  // Scoreboard: every output beat must be the next unsent beat of the source its tuser tags,
  // packets never interleave, and each packet end is followed by one idle cycle
  always @(negedge clk) if (mon_en) begin
    chk("ready_exclusive", {63'd0, ar && br}, 64'd0);
    if (gap_chk) chk("idle_gap", {63'd0, mv}, 64'd0);
    gap_chk = 0;
    if (mv && mr) begin
      if (in_pkt) chk("no_interleave", {63'd0, muser[UW-1]}, {63'd0, cur});
      if ((muser[UW-1] ? exp_b.size() : exp_a.size()) == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got %0h from src %0d with nothing pending", mdata, muser[UW-1]);
      end else begin
        eb = muser[UW-1] ? exp_b.pop_front() : exp_a.pop_front();
        chk("rand_beat", 64'({mdata, mkeep, muser, ml}), 64'(eb));
      end
      in_pkt = !ml;
      cur = muser[UW-1];
      if (ml) begin
        mcnt[muser[UW-1]]++;
        gap_chk = 1;
      end
    end
  end
  task automatic src_drv(bit s, int npkt);
    beat_t b;
    bit hs;
    int guard;
    for (int p = 0; p < npkt; p++) begin
      int len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        b = '{d: DW'($urandom), k: (DW/8)'($urandom), u: {s, 7'($urandom)}, l: i == len - 1};
        if (s) begin exp_b.push_back(b); {bdata, bkeep, buser, bl} = b; bv = 1; end
        else begin exp_a.push_back(b); {adata, akeep, auser, al} = b; av = 1; end
        guard = 0;
        do begin
          @(negedge clk);
          hs = s ? (bv && br) : (av && ar);
          @(posedge clk); #1;
          guard++;
        end while (!hs && guard < 5000);
        if (!hs) begin checks++; errors++; $display("FAIL src_handshake: src %0d stuck, got no ready, expected ready", s); end
        if (s) bv = 0; else av = 0;
      end
    end
    if (s) done_b = 1; else done_a = 1;
  endtask
  task automatic agg_pkt(int n);
    int k = 0, cyc = 0, got = 0;
    bit hs;
    @(posedge clk); #1;
    mr = 1; av = 1; adata = 32'hC0DE0000; akeep = 4'hF; auser = 8'h00; al = n == 1;
    while (got < n && cyc < 20) begin
      @(negedge clk);
      hs = mv && mr;
      if (hs) begin
        chk("agg_pkt_beat", {mdata, mkeep, muser, 19'd0, ml}, {32'hC0DE0000 + 32'(got), 4'hF, 8'(got), 19'd0, got == n - 1});
        if (got == 0) chk("agg_pkt_latency", 64'(cyc), 64'd1);
        got++;
      end
      cyc++;
      @(posedge clk); #1;
      if (hs) begin
        k++;
        av = k < n; adata = 32'hC0DE0000 + 32'(k); auser = 8'(k); al = k == n - 1;
      end
    end
    chk("agg_pkt_count", 64'(got), 64'(n));
    av = 0;
  endtask
  initial begin
    {adata, akeep, auser, al, bdata, bkeep, buser, bl, mr} = '0;
    av = 1; bv = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {61'd0, mv, ar, br}, 64'd0);
    chk("reset_cnts", {acnt, bcnt}, 64'd0);
    //  av al bv bl mr | mv ar br ml src
    add(1, 0, 1, 0, 1,  0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1,  1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 1,  1, 1, 0, 1, 0);
    add(0, 0, 1, 0, 1,  0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1,  1, 0, 1, 0, 1);
    add(1, 0, 1, 1, 1,  1, 0, 1, 1, 1);
    add(1, 0, 1, 0, 1,  0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1,  1, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0,  1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1,  0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0,  1, 0, 0, 1, 0);
    add(1, 1, 1, 1, 1,  1, 1, 0, 1, 0);
    add(1, 0, 1, 1, 1,  0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1,  1, 0, 1, 1, 1);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1,  0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1,  1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    @(posedge clk); #1 rst = 0;
    foreach (tab[i]) begin
      if (i > 0) begin @(posedge clk); #1; end
      {av, al, bv, bl, mr} = {tab[i].av, tab[i].al, tab[i].bv, tab[i].bl, tab[i].mr};
      adata = 32'hA0000000 + 32'(i); akeep = 4'hF; auser = {1'b0, 7'(i)};
      bdata = 32'hB0000000 + 32'(i); bkeep = 4'h3; buser = {1'b1, 7'(i)};
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), {61'd0, mv, ar, br}, {61'd0, tab[i].mv, tab[i].ar, tab[i].br});
      if (tab[i].mv)
        chk($sformatf("vec%0d_data", i), {mdata, mkeep, muser, 19'd0, ml},
            tab[i].src ? {bdata, 4'h3, 1'b1, 7'(i), 19'd0, tab[i].ml} : {adata, 4'hF, 1'b0, 7'(i), 19'd0, tab[i].ml});
    end
    @(negedge clk);
    chk("table_cnts", {acnt, bcnt}, {ecnt(3), ecnt(2)});
    // Reset in the middle of a 5-beat byp packet, then an agg packet must pass intact
    @(posedge clk); #1 {av, al} = 0; bv = 1; bl = 0; bdata = 1; mr = 1;
    @(posedge clk); #1 bdata = 1;
    @(negedge clk); chk("byp_beat1", {mdata, 31'd0, mv}, {32'd1, 31'd0, 1'b1});
    @(posedge clk); #1 bdata = 2;
    @(negedge clk); chk("byp_beat2", {mdata, 31'd0, mv}, {32'd2, 31'd0, 1'b1});
    @(posedge clk); #1 bdata = 3; rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("trunc_outputs", {61'd0, mv, ar, br}, 64'd0);
    chk("trunc_cnts", {acnt, bcnt}, 64'd0);
    @(posedge clk); #1 rst = 0; bv = 0;
    agg_pkt(3);
    @(negedge clk);
    chk("after_trunc_cnts", {acnt, bcnt}, {ecnt(1), ecnt(0)});
    // Randomized traffic on both inputs with random backpressure
    mcnt[0] = 1; mcnt[1] = 0;
    mon_en = 1;
    fork
      src_drv(0, 12);
      src_drv(1, 12);
      while (mon_en) begin @(posedge clk); #1 mr = $urandom_range(0, 3) != 0; end
    join_none
    for (int c = 0; c < 20000 && !(done_a && done_b && exp_a.size() == 0 && exp_b.size() == 0); c++) @(posedge clk);
    chk("rand_complete", {62'd0, done_a, done_b}, 64'd3);
    chk("rand_leftover", 64'(exp_a.size() + exp_b.size()), 64'd0);
    repeat (3) @(posedge clk);
    mon_en = 0;
    @(negedge clk);
    chk("rand_cnts", {acnt, bcnt}, {ecnt(32'(mcnt[0])), ecnt(32'(mcnt[1]))});
`ifdef MERGER_STATS_EN
    @(posedge clk); #1 mr = 1; av = 0; bv = 0;
    force dut.byp_cnt_q = 32'hFFFFFFFF;
    @(posedge clk); #1 release dut.byp_cnt_q;
    @(negedge clk); chk("preset_cnt", {32'd0, bcnt}, {32'd0, 32'hFFFFFFFF});
    @(posedge clk); #1 bv = 1; bl = 1;
    for (int c = 0; c < 10 && !(bv && br); c++) @(negedge clk);
    @(posedge clk); #1 bv = 0;
    @(negedge clk); chk("wrap_cnt", {32'd0, bcnt}, 64'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
